// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline definitions for hazard control.
// Provides the FSM state encoding and the bit positions of the load and
// reg_write flags in the 13-bit decode->execute flags vector, so callers
// extract ex_is_load / ex_reg_write consistently.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;
  localparam int FLAGS_W        = 13;
  localparam int FLAG_LOAD      = 4;
  localparam int FLAG_REG_WRITE = 3;
endpackage

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: wrapping stall/flush cycle counters with sync clear.
// Ports: clk, rst_n (async active-low), clear (zeroes both, beats increment),
//        stall_inc/flush_inc (count this cycle), stall_count/flush_count.
module hazard_perf_counters
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= clear ? '0 : stall_count + CNT_W'(stall_inc);
      flush_count <= clear ? '0 : flush_count + CNT_W'(flush_inc);
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall / branch flush sequencing for IF/ID and ID/EX.
// Ports: clk, rst_n (async active-low); decode operands id_valid, id_rs1,
//        id_rs2, id_uses_rs1, id_uses_rs2; execute side ex_rd, ex_is_load,
//        ex_reg_write, ex_branch_taken; cnt_clear; controls pc_stall,
//        if_id_stall, if_id_flush, id_ex_ena; counters stall_count, flush_count.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  input  logic             ex_branch_taken,
  input  logic             cnt_clear,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_ena,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int MAXP = LOAD_STALL_CYCLES > FLUSH_CYCLES ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;
  state_t          state, nstate;
  logic   [CW-1:0] cnt, ncnt;
  logic            load_use;
  assign load_use = id_valid & ex_is_load & ex_reg_write & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end
  // Branch wins from any state; a branch during FLUSH simply reloads the count.
  // STALL holds regardless of load_use since the bubble has already zeroed ex_rd.
  always_comb begin
    nstate      = state;
    ncnt        = cnt;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_ena   = 1'b1;
    if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_ena   = 1'b0;
      nstate      = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      ncnt        = CW'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      if_id_flush = 1'b1;
      id_ex_ena   = 1'b0;
      ncnt        = cnt - CW'(1);
      nstate      = cnt == CW'(1) ? RUN : FLUSH;
    end else if (state == STALL || load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_ena   = 1'b0;
      nstate      = state == STALL ? (cnt == CW'(1) ? RUN : STALL)
                                   : (LOAD_STALL_CYCLES > 1 ? STALL : RUN);
      ncnt        = state == STALL ? cnt - CW'(1) : CW'(LOAD_STALL_CYCLES - 1);
    end
    if (!rst_n) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b0;
      if_id_flush = 1'b1;
      id_ex_ena   = 1'b0;
    end
  end
  hazard_perf_counters #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .stall_inc  (if_id_stall),
    .flush_inc  (if_id_flush),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl over three parameter sets.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_is_load = 1'b0, ex_reg_write = 1'b0, ex_branch_taken = 1'b0, cnt_clear = 1'b0;
  logic [3:0] o0, o1, o2;
  logic [31:0] sc0, fc0, sc2, fc2;
  logic [3:0]  sc1, fc1;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    string      nm;
    int         sel;
    logic [3:0] o;
    int         sc;
    int         fc;
  } exp_t;
  exp_t q[$];
  localparam logic [3:0] NRM = 4'b0001, STL = 4'b1100, FLS = 4'b0010, RST = 4'b1010;
  always #5 clk = ~clk;
  hazard_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .pc_stall(o0[3]), .if_id_stall(o0[2]), .if_id_flush(o0[1]), .id_ex_ena(o0[0]),
    .stall_count(sc0), .flush_count(fc0));
  hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .pc_stall(o1[3]), .if_id_stall(o1[2]), .if_id_flush(o1[1]), .id_ex_ena(o1[0]),
    .stall_count(sc1), .flush_count(fc1));
  hazard_ctrl #(.FLUSH_CYCLES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken), .cnt_clear(cnt_clear),
    .pc_stall(o2[3]), .if_id_stall(o2[2]), .if_id_flush(o2[1]), .id_ex_ena(o2[0]),
    .stall_count(sc2), .flush_count(fc2));
  // kind: 0 idle, 1 load hazard on rs2, 2 rs1 matches ex_rd but rs1 unused
  task automatic step(input string nm, input int sel, input logic r, input int kind,
                      input logic [4:0] rd, input logic br, input logic clr,
                      input logic [3:0] o, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = r;
    id_valid        = kind != 0;
    ex_is_load      = kind != 0;
    ex_reg_write    = kind != 0;
    id_uses_rs2     = kind == 1;
    id_rs2          = kind == 1 ? 5'd5 : 5'd0;
    id_uses_rs1     = 1'b0;
    id_rs1          = kind == 2 ? rd : 5'd0;
    ex_rd           = rd;
    ex_branch_taken = br;
    cnt_clear       = clr;
    e.nm = nm; e.sel = sel; e.o = o; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [3:0] ao;
      int asc, afc;
      e = q.pop_front();
      ao  = e.sel == 0 ? o0 : e.sel == 1 ? o1 : o2;
      asc = e.sel == 0 ? int'(sc0) : e.sel == 1 ? int'(sc1) : int'(sc2);
      afc = e.sel == 0 ? int'(fc0) : e.sel == 1 ? int'(fc1) : int'(fc2);
      compared++;
      if (ao !== e.o || asc != e.sc || afc != e.fc) begin
        mismatched++;
        $display("FAIL %s: got ctl=%b stall_count=%0d flush_count=%0d, want ctl=%b stall_count=%0d flush_count=%0d",
                 e.nm, ao, asc, afc, e.o, e.sc, e.fc);
      end
    end
  end
  initial begin
    step("rst_d0", 0, 0, 0, 0, 0, 0, RST, 0, 0);
    step("rst_d1", 1, 0, 0, 0, 0, 0, RST, 0, 0);
    step("lu1_stall", 0, 1, 1, 5, 0, 0, STL, 0, 0);
    step("lu1_after", 0, 1, 0, 0, 0, 0, NRM, 1, 0);
    step("lu1_idle", 0, 1, 0, 0, 0, 0, NRM, 1, 0);
    step("x0_nostall", 0, 1, 1, 0, 0, 0, NRM, 1, 0);
    step("rs1_unused", 0, 1, 2, 7, 0, 0, NRM, 1, 0);
    step("br1_flush", 0, 1, 1, 5, 1, 0, FLS, 1, 0);
    step("br1_after", 0, 1, 0, 0, 0, 0, NRM, 1, 1);
    step("rst2_d1", 1, 0, 0, 0, 0, 0, RST, 0, 0);
    step("lu2_c0", 1, 1, 1, 5, 0, 0, STL, 0, 0);
    step("lu2_c1_rd0", 1, 1, 1, 0, 0, 0, STL, 1, 0);
    step("lu2_after", 1, 1, 0, 0, 0, 0, NRM, 2, 0);
    step("brlu_c0", 1, 1, 1, 5, 1, 0, FLS, 2, 0);
    step("brlu_c1", 1, 1, 1, 5, 0, 0, FLS, 2, 1);
    step("brlu_after", 1, 1, 0, 0, 0, 0, NRM, 2, 2);
    step("abort_stall", 1, 1, 1, 5, 0, 0, STL, 2, 2);
    step("abort_br", 1, 1, 0, 0, 1, 0, FLS, 3, 2);
    step("abort_fl2", 1, 1, 0, 0, 0, 0, FLS, 3, 3);
    step("abort_after", 1, 1, 0, 0, 0, 0, NRM, 3, 4);
    step("clear_issue", 1, 1, 0, 0, 0, 1, NRM, 3, 4);
    step("clear_done", 1, 1, 0, 0, 0, 0, NRM, 0, 0);
    for (int i = 0; i < 16; i++) step($sformatf("wrap_%0d", i), 1, 1, 1, 5, 0, 0, STL, i, 0);
    step("wrap_zero", 1, 1, 0, 0, 0, 0, NRM, 0, 0);
    step("clr_stall_a", 1, 1, 1, 5, 0, 0, STL, 0, 0);
    step("clr_stall_b", 1, 1, 1, 5, 0, 1, STL, 1, 0);
    step("clr_stall_z", 1, 1, 0, 0, 0, 0, NRM, 0, 0);
    step("rst3_d2", 2, 0, 0, 0, 0, 0, RST, 0, 0);
    step("f3_br", 2, 1, 0, 0, 1, 0, FLS, 0, 0);
    step("f3_c1", 2, 1, 0, 0, 0, 0, FLS, 0, 1);
    step("f3_midrst", 2, 0, 0, 0, 0, 0, RST, 0, 0);
    step("f3_release", 2, 1, 0, 0, 0, 0, NRM, 0, 0);
    step("f3_run", 2, 1, 0, 0, 0, 0, NRM, 0, 0);
    for (int i = 0; i < 4 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
